// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: imem port, redirect input, IF/ID register and status
interface fetch_stage_if #(
  parameter int N  = 64,
  parameter int AW = 6
);
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          br_taken;
  logic [N-1:0]  br_target;
  logic [31:0]   instr_d;
  logic [N-1:0]  pc_d;
  logic          valid_d;
  logic          ready_d;
  logic          halted;
  logic          fault;
  logic [31:0]   fetch_cnt;

  modport master (
    output imem_addr, instr_d, pc_d, valid_d, halted, fault, fetch_cnt,
    input  imem_q, br_taken, br_target, ready_d
  );

  modport slave (
    input  imem_addr, instr_d, pc_d, valid_d, halted, fault, fetch_cnt,
    output imem_q, br_taken, br_target, ready_d
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with IF/ID register, redirect, halt-on-zero and fault FSM
module fetch_stage #(
  parameter int N            = 64,
  parameter int AW           = 6,
  parameter int HALT_ON_ZERO = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [N-1:0] ifid_pc_q, ifid_pc_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  cnt_q, cnt_d;

  logic pc_ok;
  logic issue;
  logic zero_word;

  // Anything above the instruction-memory window is an out-of-range fetch.
  assign pc_ok     = (pc_q[N-1:AW+2] == '0);
  assign issue     = (state_q == S_RUN) && !bus.br_taken &&
                     (!ifid_valid_q || bus.ready_d) && pc_ok;
  assign zero_word = (HALT_ON_ZERO != 0) && (bus.imem_q == 32'd0);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    cnt_d        = cnt_q;

    if (state_q == S_FAULT) begin
      // FAULT is terminal: pc frozen, redirects only flush the pending entry.
      if (bus.br_taken || bus.ready_d) begin
        ifid_valid_d = 1'b0;
      end
    end else if (bus.br_taken) begin
      pc_d         = bus.br_target;
      ifid_valid_d = 1'b0;
      state_d      = (bus.br_target[1:0] == 2'b00) ? S_RUN : S_FAULT;
    end else begin
      if (ifid_valid_q && bus.ready_d) begin
        ifid_valid_d = 1'b0;
      end
      if (state_q == S_RUN) begin
        if (!pc_ok) begin
          state_d = S_FAULT;
        end else if (issue) begin
          if (zero_word) begin
            state_d = S_HALT;
          end else begin
            ifid_instr_d = bus.imem_q;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + N'(4);
            cnt_d        = cnt_q + 32'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.imem_addr = pc_q[AW+1:2];
  assign bus.instr_d   = ifid_instr_q;
  assign bus.pc_d      = ifid_pc_q;
  assign bus.valid_d   = ifid_valid_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.fault     = (state_q == S_FAULT);
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Parameters
REQ-001 The block SHALL have parameter N, default 64, giving the width of the program counter and branch target.
REQ-002 The block SHALL have parameter AW, default 6, giving the instruction-memory word-address width (64 words).
REQ-003 The block SHALL have parameter HALT_ON_ZERO, default 1; when 1, a fetched word of 32'h00000000 halts fetch.

Interface
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  reset; asynchronous and active-low.
REQ-006 imem_addr  out  AW  instruction-memory word address, equal to pc_q[AW+1:2].
REQ-007 imem_q  in  32  instruction word, valid in the same cycle as imem_addr (combinational memory).
REQ-008 br_taken  in  1  redirect request from a later stage.
REQ-009 br_target  in  N  byte address of the redirect target.
REQ-010 instr_d  out  32  IF/ID instruction register.
REQ-011 pc_d  out  N  byte address of instr_d.
REQ-012 valid_d  out  1  instr_d/pc_d hold a live instruction.
REQ-013 ready_d  in  1  decode accepts the IF/ID contents this cycle.
REQ-014 halted  out  1  FSM is in HALT.
REQ-015 fault  out  1  FSM is in FAULT.
REQ-016 fetch_cnt  out  32  number of instructions issued into IF/ID.

Function
REQ-017 The block SHALL implement states RUN, HALT and FAULT, with RUN as the reset state.
- REQ-018 It SHALL define issue = RUN && !br_taken && (!valid_d || ready_d) && pc_ok.
- pc_ok = (pc_q[N-1:AW+2] == 0).
REQ-019 On issue, at the clock edge, the block SHALL load instr_d<=imem_q, pc_d<=pc_q and valid_d<=1, and SHALL set pc_q<=pc_q+4 and fetch_cnt<=fetch_cnt+1.
REQ-020 When valid_d && !ready_d && !br_taken, the block SHALL hold pc_q, instr_d, pc_d and valid_d unchanged (stall).
REQ-021 When valid_d && ready_d and issue is false, the block SHALL clear valid_d<=0.
REQ-022 When br_taken=1, the block SHALL take priority over stall, issue and HALT:
- pc_q<=br_target and valid_d<=0 (flush); fetch_cnt unchanged.
- Next state RUN if br_target[1:0]==0, else FAULT.
- A redirect SHALL leave HALT.
REQ-023 With HALT_ON_ZERO=1, an issue with imem_q==0 SHALL NOT load IF/ID and SHALL NOT advance pc_q or fetch_cnt; the state SHALL become HALT.
REQ-024 In RUN with !pc_ok and !br_taken, the state SHALL become FAULT, with valid_d<=0 once any pending IF/ID entry is accepted.
REQ-025 FAULT SHALL be exited only by reset; pc_q SHALL freeze and no issue SHALL occur.
REQ-026 In HALT, pc_q SHALL hold its value; a valid_d entry SHALL still drain on ready_d.
REQ-027 pc_q+4 SHALL wrap modulo 2^N.
REQ-028 fetch_cnt SHALL wrap from 32'hFFFFFFFF to 0.
REQ-029 halted and fault SHALL be registered state decodes, with no combinational path from inputs.
REQ-030 imem_addr SHALL depend only on pc_q.

Reset
REQ-031 While reset_n=0, the block SHALL asynchronously force:
- pc_q=0, instr_d=0, pc_d=0, valid_d=0, fetch_cnt=0
- state=RUN, halted=0, fault=0
REQ-032 Reset asserted mid-stall or mid-redirect SHALL discard all pending state, with no IF/ID entry surviving.
REQ-033 The first issue SHALL occur on the first rising edge after reset_n deasserts, fetching address 0.

Verification
REQ-034 Straight-line run: ROM words 0..3 nonzero, word 4 zero, ready_d=1 throughout.
- valid_d=1 for 4 cycles with pc_d=0,4,8,12.
- Then halted=1, pc_q=16, fetch_cnt=4.
REQ-035 Stall: ready_d=0 for 3 cycles while valid_d=1 holding pc_d=4.
- instr_d, pc_d and pc_q=8 hold; fetch_cnt unchanged.
- On ready_d=1, pc_d=8 is issued next.
REQ-036 Redirect during stall: valid_d=1, ready_d=0, br_taken=1, br_target=0x20.
- Next cycle valid_d=0, pc_q=0x20.
- Following cycle pc_d=0x20, valid_d=1.
REQ-037 Misaligned redirect: br_target=0x22.
- fault=1 the next cycle and stays 1.
- No further issue; reset_n pulse clears fault and pc_q=0.
REQ-038 Out-of-range fetch: sequential fetch reaches pc_q=0x100 with N=64, AW=6.
- fault=1 and the last issued pc_d=0xFC.
REQ-039 Reset mid-operation: reset_n=0 asynchronously between edges.
- All outputs are 0 immediately (before the next clk edge).
- After release, fetch restarts at address 0.
